// File: rtl/uart_pkg.sv
// Shared UART definitions: data-bit encodings, transmitter FSM states, timing floor.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    UART_BITS_5 = 2'b00,
    UART_BITS_6 = 2'b01,
    UART_BITS_7 = 2'b10,
    UART_BITS_8 = 2'b11
  } uart_bits_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // Shortest legal bit time in clocks; smaller divisors are clamped up to this.
  localparam logic [15:0] UART_DIV_MIN = 16'd2;

  // Index of the last data bit of a frame (N-1).
  function automatic logic [2:0] last_bit_idx(input uart_bits_e b);
    case (b)
      UART_BITS_5: return 3'd4;
      UART_BITS_6: return 3'd5;
      UART_BITS_7: return 3'd6;
      default:     return 3'd7;
    endcase
  endfunction

  // Keeps only the bits that are actually transmitted.
  function automatic logic [7:0] data_mask(input uart_bits_e b);
    case (b)
      UART_BITS_5: return 8'h1F;
      UART_BITS_6: return 8'h3F;
      UART_BITS_7: return 8'h7F;
      default:     return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO holding queued bytes; head word is visible on pop_dat_o.
// Latency: a push is visible (level, empty, head) after the next rising edge.
// Backpressure: pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = (level_o == LVL_W'(DEPTH));
  assign empty_o   = (level_o == '0);
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + LVL_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + LVL_W'(1);
  end

  // Pointer registers; reset flushes the queue.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte stream in, queued in a FIFO, serialised LSB first.
// Latency: byte pushed into an empty, idle block drives the start bit 2 clocks later.
// Backpressure: tx_ready_o low while disabled, full, or in the first clock after reset.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [15:0]      cfg_div_i,
  input  logic             cfg_en_i,
  input  logic             cfg_parity_en_i,
  input  logic [1:0]       cfg_bits_i,
  input  logic             cfg_stop_bits_i,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic [LVL_W-1:0] fifo_level_o
);

  logic       fifo_full, fifo_empty, fifo_pop;
  logic [7:0] fifo_dat;

  tx_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d;
  uart_bits_e  nbits_q, nbits_d;
  logic        par_en_q, par_en_d;
  logic        stop2_q, stop2_d;
  logic        tx_q, tx_d;
  logic        ready_arm_q;

  logic        bit_end, can_start, load;
  logic [15:0] div_eff;
  logic [7:0]  masked;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .push_i     (tx_valid_i & tx_ready_o),
    .push_dat_i (tx_data_i),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level_o)
  );

  assign tx_ready_o = ready_arm_q & cfg_en_i & ~fifo_full;
  assign busy_o     = (state_q != TX_IDLE) | ~fifo_empty;
  assign tx_o       = tx_q;

  assign bit_end   = (cnt_q == 16'd0);
  assign can_start = ~fifo_empty & cfg_en_i;
  assign div_eff   = (cfg_div_i < UART_DIV_MIN) ? UART_DIV_MIN : cfg_div_i;
  assign masked    = fifo_dat & data_mask(uart_bits_e'(cfg_bits_i));

  // Frame sequencing; the last stop bit chains straight into the next start.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    par_d    = par_q;
    nbits_d  = nbits_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;
    load     = 1'b0;
    tx_d     = 1'b1;
    case (state_q)
      TX_IDLE: begin
        load = can_start;
      end
      TX_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = TX_DATA;
          cnt_d   = div_q - 16'd1;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        tx_d = sh_q[0];
        if (bit_end) begin
          cnt_d = div_q - 16'd1;
          sh_d  = {1'b0, sh_q[7:1]};
          if (bit_q == last_bit_idx(nbits_q)) begin
            state_d = par_en_q ? TX_PARITY : TX_STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          state_d = TX_STOP;
          cnt_d   = div_q - 16'd1;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (stop2_q && (bit_q == 3'd0)) begin
            bit_d = 3'd1;
            cnt_d = div_q - 16'd1;
          end else if (can_start) begin
            load = 1'b1;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    // Latch the head byte and a snapshot of the configuration for the new frame.
    if (load) begin
      state_d  = TX_START;
      cnt_d    = div_eff - 16'd1;
      div_d    = div_eff;
      bit_d    = 3'd0;
      sh_d     = masked;
      par_d    = ^masked;
      nbits_d  = uart_bits_e'(cfg_bits_i);
      par_en_d = cfg_parity_en_i;
      stop2_d  = cfg_stop_bits_i;
    end
    fifo_pop = load;
  end

  // Frame registers; the line is re-timed one clock behind the state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= TX_IDLE;
      cnt_q       <= '0;
      div_q       <= UART_DIV_MIN;
      bit_q       <= '0;
      sh_q        <= '0;
      par_q       <= 1'b0;
      nbits_q     <= UART_BITS_8;
      par_en_q    <= 1'b0;
      stop2_q     <= 1'b0;
      tx_q        <= 1'b1;
      ready_arm_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      par_q       <= par_d;
      nbits_q     <= nbits_d;
      par_en_q    <= par_en_d;
      stop2_q     <= stop2_d;
      tx_q        <= tx_d;
      ready_arm_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed frame pins plus randomized traffic against a line model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] cfg_div;
  logic        cfg_en, cfg_par, cfg_stop;
  logic [1:0]  cfg_bits;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready_o, tx_o, busy_o;
  logic [3:0]  fifo_level_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: queued bytes, per-clock expected line samples, clocks left in frame.
  logic [7:0] mq[$];
  logic       line[$];
  int         rem;
  bit         started;
  logic       exp_tx;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .cfg_div_i       (cfg_div),
    .cfg_en_i        (cfg_en),
    .cfg_parity_en_i (cfg_par),
    .cfg_bits_i      (cfg_bits),
    .cfg_stop_bits_i (cfg_stop),
    .tx_data_i       (tx_data),
    .tx_valid_i      (tx_valid),
    .tx_ready_o      (tx_ready_o),
    .tx_o            (tx_o),
    .busy_o          (busy_o),
    .fifo_level_o    (fifo_level_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expand one byte into per-clock line samples using the current configuration.
  task automatic model_frame(input logic [7:0] b);
    int d, n;
    logic p;
    d = (cfg_div < 16'd2) ? 2 : int'(cfg_div);
    n = 5 + int'(cfg_bits);
    p = 1'b0;
    repeat (d) line.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      p = p ^ b[i];
      repeat (d) line.push_back(b[i]);
    end
    if (cfg_par) repeat (d) line.push_back(p);
    repeat (d * (cfg_stop ? 2 : 1)) line.push_back(1'b1);
    rem = d * (1 + n + (cfg_par ? 1 : 0) + (cfg_stop ? 2 : 1));
  endtask

  // Single compare process: advance model on each edge, compare on the falling edge.
  initial begin
    rem = 0; started = 1'b0; exp_tx = 1'b1;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        mq.delete(); line.delete(); rem = 0; started = 1'b0; exp_tx = 1'b1;
      end else begin
        bit ready_b, push, pop;
        logic [7:0] pdat;
        ready_b = started && cfg_en && (mq.size() < DEPTH);
        push    = tx_valid && ready_b;
        pdat    = tx_data;
        exp_tx  = (line.size() > 0) ? line.pop_front() : 1'b1;
        pop     = (rem <= 1) && (mq.size() > 0) && cfg_en;
        if (pop) model_frame(mq.pop_front());
        else if (rem > 0) rem--;
        if (push) mq.push_back(pdat);
        started = 1'b1;
      end
      @(negedge clk);
      if (!rstn) begin
        chk("rst_tx", tx_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_level", fifo_level_o, 0);
        chk("rst_ready", tx_ready_o, 0);
      end else begin
        chk("tx", tx_o, exp_tx);
        chk("busy", busy_o, (rem > 0 || mq.size() > 0) ? 1 : 0);
        chk("level", fifo_level_o, mq.size());
        chk("ready", tx_ready_o, (started && cfg_en && mq.size() < DEPTH) ? 1 : 0);
      end
    end
  end

  task automatic set_cfg(input int div, input logic [1:0] bits, input logic par, input logic stop);
    cfg_div = 16'(div); cfg_bits = bits; cfg_par = par; cfg_stop = stop; cfg_en = 1'b1;
  endtask

  // From the home slot (posedge+2): push one byte, ending at home after the push edge.
  task automatic push_one(input logic [7:0] b);
    tx_valid = 1'b1; tx_data = b;
    @(posedge clk); #2;
    tx_valid = 1'b0;
  endtask

  // Hand-computed frame pins; called at home right after the push edge N.
  task automatic check_frame(input string tag, input int div, input logic [15:0] bits, input int nb);
    @(posedge clk); #4; chk({tag, "_idle_n1"}, tx_o, 1);
    @(posedge clk); #4; chk({tag, "_start_n2"}, tx_o, 0);
    for (int i = 0; i < nb; i++) begin
      repeat (i == 0 ? div / 2 : div) @(posedge clk);
      #4; chk($sformatf("%s_bit%0d", tag, i), tx_o, bits[i]);
    end
    repeat (div - 2 - div / 2) @(posedge clk);
    #4; chk({tag, "_busy_last"}, busy_o, 1);
    @(posedge clk); #4; chk({tag, "_busy_end"}, busy_o, 0);
    @(posedge clk); #2;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while ((busy_o || line.size() > 0) && k < bound) begin
      @(posedge clk); #4; k++;
    end
    chk("drain_done", busy_o, 0);
    @(posedge clk); #2;
  endtask

  initial begin
    int acc;
    rstn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    set_cfg(434, 2'b11, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk); #2;

    // 8N1, div 434, 0x55: start, 1,0,1,0,1,0,1,0, stop.
    push_one(8'h55);
    check_frame("8n1", 434, 16'h02AA, 10);

    // 7E2, div 16, 0x41: start, 1,0,0,0,0,0,1, parity 0, stop, stop.
    set_cfg(16, 2'b10, 1'b1, 1'b1);
    push_one(8'h41);
    check_frame("7e2", 16, 16'h0682, 11);

    // Fill: valid held 12 clocks, 1 byte in the shifter + DEPTH queued.
    set_cfg(16, 2'b11, 1'b0, 1'b0);
    acc = 0;
    tx_valid = 1'b1;
    repeat (12) begin
      #2; if (tx_ready_o) acc++;
      @(posedge clk); #2;
      tx_data = tx_data + 8'd1;
    end
    tx_valid = 1'b0;
    #2;
    chk("fill_accepted", acc, 9);
    chk("fill_level", fifo_level_o, 8);
    chk("fill_ready", tx_ready_o, 0);
    wait_idle(5000);

    // Disable mid-frame: current frame finishes, remaining bytes stay queued.
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'hA0 + 8'(i);
      @(posedge clk); #2;
    end
    tx_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 cfg_en = 1'b0;
    repeat (200) @(posedge clk);
    #4;
    chk("dis_tx", tx_o, 1);
    chk("dis_level", fifo_level_o, 2);
    chk("dis_busy", busy_o, 1);
    @(posedge clk); #2 cfg_en = 1'b1;
    wait_idle(2000);

    // Reset during DATA with 4 queued: line goes high immediately.
    tx_valid = 1'b1; tx_data = 8'h00;
    repeat (5) begin @(posedge clk); #2; end
    tx_valid = 1'b0;
    repeat (40) @(posedge clk);
    #3 rstn = 1'b0;
    #1 chk("rst_mid_tx", tx_o, 1);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (50) @(posedge clk);
    #4;
    chk("rst_after_level", fifo_level_o, 0);
    chk("rst_after_busy", busy_o, 0);
    chk("rst_after_tx", tx_o, 1);
    @(posedge clk); #2;

    // Randomized traffic, including configuration changes mid-frame.
    set_cfg(4, 2'b11, 1'b0, 1'b0);
    repeat (6000) begin
      tx_valid = ($urandom_range(0, 2) != 0);
      tx_data  = 8'($urandom);
      if ($urandom_range(0, 40) == 0) begin
        cfg_div  = 16'($urandom_range(0, 12));
        cfg_bits = 2'($urandom_range(0, 3));
        cfg_par  = 1'($urandom_range(0, 1));
        cfg_stop = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 80) == 0) cfg_en = ~cfg_en;
      @(posedge clk); #2;
    end
    tx_valid = 1'b0; cfg_en = 1'b1;
    wait_idle(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: time %0t reached, required finish earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: accepts bytes on a valid/ready stream, queues them in an internal FIFO, serialises them onto a single line.
- Serves as the driving end for uart_rx instances, both on chip and in board benches (console TX, secondary command/data UART).
- Config port set matches uart_rx so one register block can feed both directions.

Parameters:
- FIFO_DEPTH, 8, number of queued bytes (power of two, >=2), excluding the byte in the shifter.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the fill-level output.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_div_i  in  16  clocks per bit (434 = 115200 baud @ 50 MHz)
- cfg_en_i  in  1  transmitter enable
- cfg_parity_en_i  in  1  append even-parity bit
- cfg_bits_i  in  2  data bits: 00=5, 01=6, 10=7, 11=8
- cfg_stop_bits_i  in  1  0=1 stop bit, 1=2 stop bits
- tx_data_i  in  8  byte to send, LSB first; unused MSBs ignored
- tx_valid_i  in  1  byte valid
- tx_ready_o  out  1  byte accepted when valid&ready at rising clk
- tx_o  out  1  serial line, idle high
- busy_o  out  1  frame in progress or FIFO non-empty
- fifo_level_o  out  LVL_W  bytes currently queued in FIFO

Behaviour:
- Reset (async assert, sync release): tx_o=1, busy_o=0, tx_ready_o=0 until first clock after release, fifo_level_o=0; FIFO flushed; FSM=IDLE.
- tx_ready_o = cfg_en_i & ~fifo_full, registered-free (combinational from state). Push on valid&ready.
- FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: if FIFO non-empty and cfg_en_i=1, pop head, latch byte and all cfg_* inputs into frame registers, go START. Config changes mid-frame have no effect until the next frame.
  - START: tx_o=0 for one bit time.
  - DATA: shift out N data bits LSB first, N from latched cfg_bits.
  - PARITY (only if latched parity_en): tx_o = XOR of the N data bits (even parity).
  - STOP: tx_o=1 for 1 or 2 bit times, then IDLE. Back-to-back frames: the next START begins the cycle after the last STOP bit ends (no extra idle).
- Bit timing: a bit counter reloads on every bit boundary; each bit lasts exactly max(cfg_div_i,2) clocks.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM idle makes tx_o fall at edge N+2. It holds low for div clocks.
- Frame length in clocks = div*(1+N+P+S).
- cfg_en_i low:
  - tx_ready_o=0.
  - IDLE does not pop.
  - A frame in progress completes normally.
  - Queued bytes remain queued.
- busy_o = (state!=IDLE) | (fifo_level_o!=0).
- Full FIFO:
  - Push is blocked by ready=0.
  - A pop and a push in the same cycle are legal when not full; the level is unchanged.
- Empty FIFO: no pop; tx_o stays 1.
- Reset mid-frame: tx_o returns to 1 immediately (async); the partial frame is abandoned and the queue is lost.

Decomposition:
- Shared package uart_pkg:
  - enum for cfg_bits encodings (UART_BITS_5..UART_BITS_8).
  - FSM state typedef (TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP).
  - Constant UART_DIV_MIN=2.
- One sub-module, uart_sync_fifo:
  - Parameters: WIDTH=8, DEPTH.
  - Ports: push/pop/full/empty/level, with the same clk_i/rstn_i.
- Shifter, bit timer and FSM stay in uart_tx_fifo.

Test Plan:
- 8N1, div=434, push 0x55 -> tx_o low at +2 clocks for 434 clocks, then bits 1,0,1,0,1,0,1,0, then stop high. Total frame 4340 clocks; busy_o falls at end of stop.
- Loopback into uart_rx (div=434, bits=11), push 00 00 FF 00 00 00 00 00 back-to-back -> receiver reports the same 8 bytes in order with err_o=0. Frames are contiguous (no idle gap between stop and next start).
- 7E2 (bits=10, parity_en=1, stop=1), div=16, push 0x41 -> 7 data bits 1,0,0,0,0,0,1, parity 0, two stop bits. Frame = 16*11 = 176 clocks.
- FIFO_DEPTH=8, hold tx_valid_i high for 12 bytes -> exactly 9 accepted before tx_ready_o drops (1 in shifter + 8 queued), fifo_level_o=8. Ready returns 1 clock after the first frame's pop of the next byte.
- Push 3 bytes, deassert cfg_en_i mid-first-frame -> first frame completes, tx_o stays high, fifo_level_o=2, busy_o=1. Re-enable -> remaining 2 bytes sent.
- Assert rstn_i=0 during DATA of a frame with 4 queued -> tx_o=1 same cycle; after release level=0, busy_o=0, no further activity.
